// File: rtl/srmem_dbuf_ctrl.sv
// Purpose : double-buffered shift-register memory for the mask-share path; the
//           writer fills one bank of LEN_SRMEM x NUM_RDPORT entries while the
//           reader drains (or recirculates) the other.
// Latency : a bank closed at edge N is readable (rdvalid, row 0 on dout) in cycle N+1;
//           a pop at edge N presents the next row in cycle N+1.
// Backpressure: wrfull high while the write bank is still unreleased, and
//           valid_din is ignored then; req_pop is ignored while rdvalid is low.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   valid_din, din           write strobe and payload (stored as {1'b1, din})
//   is_lastdin               accepted write closes the bank
//   wrfull, wrend            write bank full; pulse when an accepted write closes a bank
//   req_pop, req_newdata     consume head row; on the final row, release (1) or recirculate (0)
//   rdvalid, dout            read bank holds a closed fill; head row, column I at [I*(DATA_BW+1) +: DATA_BW+1]
//   rdlast, rdend            pop is on the final row; pop releases the bank
//   bank_cnt                 closed, unreleased banks (0..2)

module srmem_dbuf_ctrl #(
  parameter int NUM_RDPORT = 4,
  parameter int LEN_SRMEM  = 8,
  parameter int DATA_BW    = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              valid_din,
  input  logic [DATA_BW-1:0]                din,
  input  logic                              is_lastdin,
  output logic                              wrfull,
  output logic                              wrend,
  input  logic                              req_pop,
  input  logic                              req_newdata,
  output logic                              rdvalid,
  output logic [NUM_RDPORT*(DATA_BW+1)-1:0] dout,
  output logic                              rdlast,
  output logic                              rdend,
  output logic [1:0]                        bank_cnt
);

  localparam int EW  = DATA_BW + 1;
  localparam int RW  = $clog2(LEN_SRMEM);
  localparam int CW  = (NUM_RDPORT > 1) ? $clog2(NUM_RDPORT) : 1;
  localparam int NRW = RW + 1;

  logic                 wr_bank;
  logic                 rd_bank;
  logic [1:0]           bank_full;
  logic [RW-1:0]        wrrow;
  logic [CW-1:0]        wrcol;
  logic [RW-1:0]        rdrow;
  logic [NRW-1:0]       nrows [2];
  logic [EW-1:0]        mem   [2][LEN_SRMEM][NUM_RDPORT];

  logic                 wr_acc;
  logic                 wr_at_end;
  logic                 wr_close;
  logic                 pop;
  logic [NRW-1:0]       rd_last_row;
  logic                 rd_at_last;
  logic                 rd_release;

  assign wrfull      = bank_full[wr_bank];
  assign rdvalid     = bank_full[rd_bank];

  assign wr_acc      = valid_din & ~wrfull;
  // Landing on the very last slot closes the bank even without is_lastdin.
  assign wr_at_end   = (wrrow == RW'(LEN_SRMEM - 1)) && (wrcol == CW'(NUM_RDPORT - 1));
  assign wr_close    = wr_acc & (is_lastdin | wr_at_end);
  assign wrend       = wr_close;

  assign pop         = req_pop & rdvalid;
  assign rd_last_row = nrows[rd_bank] - NRW'(1);
  assign rd_at_last  = ({1'b0, rdrow} == rd_last_row);
  assign rdlast      = pop & rd_at_last;
  assign rd_release  = rdlast & req_newdata;
  assign rdend       = rd_release;

  // Closed banks are exactly those with bank_full set, so the count follows
  // close/release (and asynchronous reset) with no extra state.
  assign bank_cnt    = {1'b0, bank_full[0]} + {1'b0, bank_full[1]};

  // Pointer and bank bookkeeping. A release and a write never hit the same
  // bank in one cycle: the write would have seen wrfull=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
      wrrow     <= '0;
      wrcol     <= '0;
      rdrow     <= '0;
      nrows[0]  <= '0;
      nrows[1]  <= '0;
    end else begin
      if (wr_acc) begin
        if (wr_close) begin
          bank_full[wr_bank] <= 1'b1;
          nrows[wr_bank]     <= NRW'(wrrow) + NRW'(1);
          wr_bank            <= ~wr_bank;
          wrrow              <= '0;
          wrcol              <= '0;
        end else if (wrcol == CW'(NUM_RDPORT - 1)) begin
          wrcol <= '0;
          wrrow <= wrrow + RW'(1);
        end else begin
          wrcol <= wrcol + CW'(1);
        end
      end
      if (pop) begin
        if (rd_at_last) begin
          rdrow <= '0;
          if (req_newdata) begin
            bank_full[rd_bank] <= 1'b0;
            rd_bank            <= ~rd_bank;
          end
        end else begin
          rdrow <= rdrow + RW'(1);
        end
      end
    end
  end

  // Storage. Releasing a bank drops its valid bits so a later short fill
  // reads the untouched slots as invalid padding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < LEN_SRMEM; r++)
          for (int c = 0; c < NUM_RDPORT; c++)
            mem[b][r][c] <= '0;
    end else begin
      if (rd_release) begin
        for (int r = 0; r < LEN_SRMEM; r++)
          for (int c = 0; c < NUM_RDPORT; c++)
            mem[rd_bank][r][c][DATA_BW] <= 1'b0;
      end
      if (wr_acc)
        mem[wr_bank][wrrow][wrcol] <= {1'b1, din};
    end
  end

  always_comb begin
    dout = '0;
    if (rdvalid) begin
      for (int c = 0; c < NUM_RDPORT; c++)
        dout[c*EW +: EW] = mem[rd_bank][rdrow][c];
    end
  end

endmodule

// File: tb/tb_srmem_dbuf_ctrl.sv
module tb_srmem_dbuf_ctrl;

  localparam int NP = 4;
  localparam int EW = 17;
  localparam int DW = NP * EW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_din = 1'b0;
  logic [15:0]   din = '0;
  logic          is_lastdin = 1'b0;
  logic          wrfull;
  logic          wrend;
  logic          req_pop = 1'b0;
  logic          req_newdata = 1'b0;
  logic          rdvalid;
  logic [DW-1:0] dout;
  logic          rdlast;
  logic          rdend;
  logic [1:0]    bank_cnt;

  int errors = 0;
  int checks = 0;

  srmem_dbuf_ctrl #(.NUM_RDPORT(4), .LEN_SRMEM(8), .DATA_BW(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_din(valid_din), .din(din), .is_lastdin(is_lastdin),
    .wrfull(wrfull), .wrend(wrend), .req_pop(req_pop), .req_newdata(req_newdata),
    .rdvalid(rdvalid), .dout(dout), .rdlast(rdlast), .rdend(rdend), .bank_cnt(bank_cnt)
  );

  always #5 clk = ~clk;

  // Row r of a fill starting at base: first nvalid columns are {1, base+4r+c}, rest zero.
  function automatic logic [DW-1:0] exp_row(input logic [15:0] base, input int r, input int nvalid);
    logic [DW-1:0] v;
    v = '0;
    for (int c = 0; c < NP; c++)
      if (c < nvalid) v[c*EW +: EW] = {1'b1, 16'(base + 16'(r*4 + c))};
    return v;
  endfunction

  // Stimulus phase: inputs change 1 time unit after a rising edge.
  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [15:0] d, input logic l, output logic we);
    valid_din = 1'b1; din = d; is_lastdin = l;
    #1 we = wrend;
    @(posedge clk); #1;
    valid_din = 1'b0; din = '0; is_lastdin = 1'b0;
  endtask

  task automatic do_pop(input logic nd, output logic [DW-1:0] row, output logic lst, output logic rend);
    req_pop = 1'b1; req_newdata = nd;
    #1 row = dout; lst = rdlast; rend = rdend;
    @(posedge clk); #1;
    req_pop = 1'b0; req_newdata = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    req_pop = 1'b1; req_newdata = 1'b1;
    #1;
    checks++; if (rdvalid !== 1'b0) begin errors++; $display("FAIL reset_rdvalid got=%b exp=0", rdvalid); end
    checks++; if (wrfull !== 1'b0) begin errors++; $display("FAIL reset_wrfull got=%b exp=0", wrfull); end
    checks++; if (bank_cnt !== 2'd0) begin errors++; $display("FAIL reset_bank_cnt got=%0d exp=0", bank_cnt); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got=%h exp=0", dout); end
    checks++; if ({wrend, rdlast, rdend} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {wrend, rdlast, rdend}); end
    @(posedge clk); #1;
    req_pop = 1'b0; req_newdata = 1'b0;
    checks++; if (rdvalid !== 1'b0) begin errors++; $display("FAIL reset_ignored_pop got=%b exp=0", rdvalid); end
  endtask

  task automatic test_full_fill();
    logic we, lst, rend;
    logic [DW-1:0] row;
    int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      do_write(16'h1000 + 16'(i), i == 31, we);
      if (we !== (i == 31)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL full_wrend bad_writes=%0d exp=0", bad); end
    checks++; if (rdvalid !== 1'b1) begin errors++; $display("FAIL full_rdvalid got=%b exp=1", rdvalid); end
    checks++; if (bank_cnt !== 2'd1) begin errors++; $display("FAIL full_bank_cnt got=%0d exp=1", bank_cnt); end
    checks++; if (wrfull !== 1'b0) begin errors++; $display("FAIL full_wrfull got=%b exp=0", wrfull); end
    for (int r = 0; r < 8; r++) begin
      do_pop(1'b1, row, lst, rend);
      checks++; if (row !== exp_row(16'h1000, r, 4)) begin errors++; $display("FAIL full_row%0d got=%h exp=%h", r, row, exp_row(16'h1000, r, 4)); end
      checks++; if ({lst, rend} !== {2{r == 7}}) begin errors++; $display("FAIL full_last_end%0d got=%b%b exp=%b", r, lst, rend, {2{r == 7}}); end
    end
    checks++; if ({rdvalid, bank_cnt} !== 3'b000) begin errors++; $display("FAIL full_after_release got=%b exp=000", {rdvalid, bank_cnt}); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL full_dout_idle got=%h exp=0", dout); end
  endtask

  task automatic test_short_fill();
    logic we, lst, rend;
    logic [DW-1:0] row;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      do_write(16'h2000 + 16'(i), i == 5, we);
      if (i == 4) begin checks++; if (we !== 1'b0) begin errors++; $display("FAIL short_wrend_early got=%b exp=0", we); end end
      if (i == 5) begin checks++; if (we !== 1'b1) begin errors++; $display("FAIL short_wrend got=%b exp=1", we); end end
    end
    do_pop(1'b1, row, lst, rend);
    checks++; if (row !== exp_row(16'h2000, 0, 4)) begin errors++; $display("FAIL short_row0 got=%h exp=%h", row, exp_row(16'h2000, 0, 4)); end
    checks++; if (lst !== 1'b0) begin errors++; $display("FAIL short_rdlast_pop1 got=%b exp=0", lst); end
    do_pop(1'b1, row, lst, rend);
    checks++; if (row !== exp_row(16'h2000, 1, 2)) begin errors++; $display("FAIL short_row1 got=%h exp=%h", row, exp_row(16'h2000, 1, 2)); end
    checks++; if ({lst, rend} !== 2'b11) begin errors++; $display("FAIL short_last_end got=%b%b exp=11", lst, rend); end
    checks++; if (rdvalid !== 1'b0) begin errors++; $display("FAIL short_released got=%b exp=0", rdvalid); end
  endtask

  task automatic test_ping_pong();
    logic we, lst, rend;
    logic [DW-1:0] row;
    int bad;
    apply_reset();
    for (int i = 0; i < 32; i++) do_write(16'h3000 + 16'(i), i == 31, we);
    for (int i = 0; i < 32; i++) do_write(16'h4000 + 16'(i), i == 31, we);
    checks++; if ({wrfull, bank_cnt} !== 3'b110) begin errors++; $display("FAIL pp_full got=%b exp=110", {wrfull, bank_cnt}); end
    do_write(16'h5000, 1'b1, we);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL pp_ignored_wrend got=%b exp=0", we); end
    checks++; if ({wrfull, bank_cnt} !== 3'b110) begin errors++; $display("FAIL pp_still_full got=%b exp=110", {wrfull, bank_cnt}); end
    bad = 0;
    for (int r = 0; r < 8; r++) begin
      do_pop(1'b1, row, lst, rend);
      if (row !== exp_row(16'h3000, r, 4)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL pp_bank0_rows bad_rows=%0d exp=0", bad); end
    checks++; if ({wrfull, bank_cnt, rdvalid} !== 4'b0011) begin errors++; $display("FAIL pp_release got=%b exp=0011", {wrfull, bank_cnt, rdvalid}); end
    checks++; if (dout !== exp_row(16'h4000, 0, 4)) begin errors++; $display("FAIL pp_bank1_row0 got=%h exp=%h", dout, exp_row(16'h4000, 0, 4)); end
  endtask

  task automatic test_recirculate();
    logic we, lst, rend;
    logic [DW-1:0] row;
    apply_reset();
    for (int i = 0; i < 12; i++) do_write(16'h6000 + 16'(i), i == 11, we);
    for (int r = 0; r < 3; r++) begin
      do_pop(1'b0, row, lst, rend);
      checks++; if (row !== exp_row(16'h6000, r, 4)) begin errors++; $display("FAIL recirc_row%0d got=%h exp=%h", r, row, exp_row(16'h6000, r, 4)); end
      if (r == 2) begin checks++; if ({lst, rend} !== 2'b10) begin errors++; $display("FAIL recirc_last_end got=%b%b exp=10", lst, rend); end end
    end
    do_pop(1'b0, row, lst, rend);
    checks++; if (row !== exp_row(16'h6000, 0, 4)) begin errors++; $display("FAIL recirc_wrap got=%h exp=%h", row, exp_row(16'h6000, 0, 4)); end
    checks++; if ({lst, bank_cnt} !== 3'b001) begin errors++; $display("FAIL recirc_cnt got=%b exp=001", {lst, bank_cnt}); end
  endtask

  task automatic test_overflow_reset();
    logic we, lst, rend;
    logic [DW-1:0] row;
    int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      do_write(16'h7000 + 16'(i), 1'b0, we);
      if (we !== (i == 31)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ovf_wrend bad_writes=%0d exp=0", bad); end
    checks++; if (rdvalid !== 1'b1) begin errors++; $display("FAIL ovf_rdvalid got=%b exp=1", rdvalid); end
    for (int r = 0; r < 3; r++) do_pop(1'b1, row, lst, rend);
    req_pop = 1'b1; req_newdata = 1'b1;
    #1;
    checks++; if (dout !== exp_row(16'h7000, 3, 4)) begin errors++; $display("FAIL ovf_row3 got=%h exp=%h", dout, exp_row(16'h7000, 3, 4)); end
    rst_n = 1'b0;
    #1;
    checks++; if ({rdvalid, bank_cnt} !== 3'b000) begin errors++; $display("FAIL ovf_async_reset got=%b exp=000", {rdvalid, bank_cnt}); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL ovf_async_dout got=%h exp=0", dout); end
    @(posedge clk); #1;
    req_pop = 1'b0; req_newdata = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_simul_close_release();
    logic we, lst, rend;
    logic [DW-1:0] row;
    apply_reset();
    for (int i = 0; i < 4; i++) do_write(16'h8000 + 16'(i), i == 3, we);
    for (int i = 0; i < 7; i++) do_write(16'h9000 + 16'(i), 1'b0, we);
    valid_din = 1'b1; din = 16'h9007; is_lastdin = 1'b1;
    req_pop = 1'b1; req_newdata = 1'b1;
    #1;
    checks++; if ({wrend, rdlast, rdend} !== 3'b111) begin errors++; $display("FAIL simul_pulses got=%b exp=111", {wrend, rdlast, rdend}); end
    checks++; if (dout !== exp_row(16'h8000, 0, 4)) begin errors++; $display("FAIL simul_bank0 got=%h exp=%h", dout, exp_row(16'h8000, 0, 4)); end
    @(posedge clk); #1;
    valid_din = 1'b0; din = '0; is_lastdin = 1'b0;
    req_pop = 1'b0; req_newdata = 1'b0;
    checks++; if ({bank_cnt, rdvalid, wrfull} !== 4'b0110) begin errors++; $display("FAIL simul_state got=%b exp=0110", {bank_cnt, rdvalid, wrfull}); end
    checks++; if (dout !== exp_row(16'h9000, 0, 4)) begin errors++; $display("FAIL simul_bank1_row0 got=%h exp=%h", dout, exp_row(16'h9000, 0, 4)); end
    do_pop(1'b1, row, lst, rend);
    do_pop(1'b1, row, lst, rend);
    checks++; if ({row, lst, rend} !== {exp_row(16'h9000, 1, 4), 2'b11}) begin errors++; $display("FAIL simul_bank1_row1 got=%h/%b%b exp=%h/11", row, lst, rend, exp_row(16'h9000, 1, 4)); end
  endtask

  initial begin
    test_reset();
    test_full_fill();
    test_short_fill();
    test_ping_pong();
    test_recirculate();
    test_overflow_reset();
    test_simul_close_release();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
